// File: rtl/pdm_tx_modulator.sv
// FIFO-buffered PCM-to-PDM transmitter using a first-order carry-out sigma-delta modulator.
// Optional build macro PDM_TX_DITHER_EN adds LFSR dither to the modulator input.
module pdm_tx_modulator #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    parameter int OSR   = 64
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   ce_pdm,
    input  logic                   enable,
    input  logic                   mclear,
    input  logic [N-1:0]           pcm_data_i,
    input  logic                   pcm_valid_i,
    output logic                   pcm_ready_o,
    output logic                   pdm_data_o,
    output logic [$clog2(DEPTH):0] fill_o,
    output logic                   underrun_o,
    output logic                   busy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(OSR);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OSR - 1);
    localparam logic [AW:0]   FILL_FULL = (AW + 1)'(DEPTH);
    localparam logic [N-1:0]  OFFSET    = {1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
    state_t state, state_next;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fill;
    logic          push, pop;

    logic [N-1:0]  acc, acc_next, hold, hold_next, u;
    logic [CW-1:0] cnt, cnt_next;
    logic [N:0]    sum;
    logic          pdm, pdm_next, underrun, underrun_set;

    assign pcm_ready_o = (fill != FILL_FULL);
    assign push        = pcm_valid_i & pcm_ready_o;

    assign pdm_data_o = pdm;
    assign fill_o     = fill;
    assign underrun_o = underrun;
    assign busy_o     = (state == RUN);

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem[wr_ptr] <= pcm_data_i;
        end
    end

    // Pops only ever see the registered occupancy, so a same-cycle push into an empty FIFO is not visible.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

`ifdef PDM_TX_DITHER_EN
    logic [15:0] lfsr, lfsr_next;
    logic [N:0]  u_ext;

    always_comb begin
        u_ext = {1'b0, hold + OFFSET} + {{(N - 3){1'b0}}, lfsr[3:0]};
        u     = u_ext[N] ? '1 : u_ext[N-1:0];
    end
`else
    assign u = hold + OFFSET;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            hold     <= '0;
            pdm      <= 1'b0;
            underrun <= 1'b0;
`ifdef PDM_TX_DITHER_EN
            lfsr     <= 16'hACE1;
`endif
        end else begin
            state <= state_next;
            acc   <= acc_next;
            cnt   <= cnt_next;
            hold  <= hold_next;
            pdm   <= pdm_next;
`ifdef PDM_TX_DITHER_EN
            lfsr  <= lfsr_next;
`endif
            if (underrun_set) begin
                underrun <= 1'b1;
            end else if (mclear) begin
                underrun <= 1'b0;
            end
        end
    end

    // Dropping enable overrides everything else, including a strobe in the same cycle.
    always_comb begin
        state_next   = state;
        acc_next     = acc;
        cnt_next     = cnt;
        hold_next    = hold;
        pdm_next     = pdm;
        pop          = 1'b0;
        underrun_set = 1'b0;
        sum          = '0;
`ifdef PDM_TX_DITHER_EN
        lfsr_next    = lfsr;
`endif
        if (!enable) begin
            state_next = IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            pdm_next   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = PRIME;
                    acc_next   = '0;
                    cnt_next   = '0;
                    pdm_next   = 1'b0;
                end
                PRIME: begin
                    if (ce_pdm) begin
                        if (fill != '0) begin
                            pop        = 1'b1;
                            hold_next  = mem[rd_ptr];
                            cnt_next   = '0;
                            state_next = RUN;
                        end else begin
                            pdm_next = ~pdm;
                        end
                    end
                end
                RUN: begin
                    if (ce_pdm) begin
                        sum      = {1'b0, acc} + {1'b0, u};
                        pdm_next = sum[N];
                        acc_next = sum[N-1:0];
`ifdef PDM_TX_DITHER_EN
                        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
                        // A failed fetch keeps replaying the current sample.
                        if (cnt == CNT_LAST) begin
                            cnt_next = '0;
                            if (fill != '0) begin
                                pop       = 1'b1;
                                hold_next = mem[rd_ptr];
                            end else begin
                                underrun_set = 1'b1;
                            end
                        end else begin
                            cnt_next = cnt + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule
